deferred_step_control: RTL and testbench
========================================

// Module: deferred_step_control
// PURPOSE
//   Batches per-cycle difftest step counts and hands them to the software checker
//   as occasional bulk requests instead of one request per cycle. Returns the
//   checker's verdict as an 8-bit result code to the simulation endpoint, which
//   uses it to finish, abort, clear or dump performance counters.
// PARAMETERS
//   STEPWIDTH      8     width of per-cycle step count input
//   ACC_WIDTH      32    width of step accumulator and request count
//   DEFER_INTERVAL 1024  cycles between periodic flushes (>=2)
// PORTS
//   clock        in   1          sole clock, rising edge
//   reset        in   1          asynchronous, active-low (asserted at 0)
//   step         in   STEPWIDTH  instructions committed this cycle (0 = none)
//   req_valid    out  1          bulk step request to checker pending
//   req_ready    in   1          checker accepts request this cycle
//   req_nstep    out  ACC_WIDTH  steps carried by the request, stable while req_valid
//   resp_valid   in   1          checker verdict present this cycle
//   resp_result  in   8          verdict: 0 none, 1 GOODTRAP, 2 EXCEED, 3 FAIL, 4 WARMUP
//   simv_result  out  8          result code to endpoint (same encoding)
// BEHAVIOUR
//   - Reset (reset==0): acc=0, interval counter=0, req_valid=0, req_nstep=0,
//     awaiting=0, simv_result=0, terminal=0. Takes effect immediately, mid-request too.
//   - States: IDLE, REQ (req_valid=1), WAIT (accepted, awaiting verdict), DONE (terminal).
//   - acc += step every cycle in all states except DONE; interval counter increments
//     each cycle in IDLE, reset to 0 on flush.
//   - Flush in IDLE when (acc+step)!=0 and (counter==DEFER_INTERVAL-1 or
//     acc >= 2^ACC_WIDTH-1 - (2^STEPWIDTH-1)). Flush cycle: req_nstep<=acc+step,
//     acc<=0, req_valid<=1 next cycle (one-cycle latency), -> REQ.
//   - Counter expiry with acc+step==0: no request; counter wraps to 0.
//   - REQ: req_valid/req_nstep held until req_ready==1; on handshake req_valid<=0, -> WAIT.
//   - WAIT: on resp_valid, -> IDLE (or DONE if terminal code). Only one outstanding
//     request; resp_valid in IDLE/REQ/DONE is ignored.
//   - simv_result: 0 by default. resp code 4 (WARMUP) -> simv_result=4 for exactly
//     one cycle after resp. Code 0 -> stays 0. Codes 1/2/3 -> simv_result set the
//     cycle after resp and held (sticky) until reset; enter DONE, no further requests.
//   - Codes >4 treated as 0.
//   - Overflow: in REQ/WAIT acc saturates at 2^ACC_WIDTH-1; on saturation simv_result<=3
//     (sticky FAIL), -> DONE.
//   - Step arriving in the same cycle as a handshake or response is accumulated, never lost.
//   - Widths: step zero-extended to ACC_WIDTH; all arithmetic unsigned.
// TESTING
//   - Reset: drive reset=0 mid-REQ -> req_valid=0, simv_result=0, acc cleared at once.
//   - DEFER_INTERVAL=4, step=1 every cycle, req_ready=1 -> req_valid pulses every 4 cycles,
//     req_nstep=4 (first flush after reset 4).
//   - Hold req_ready=0 for 10 cycles while step=2 -> req_nstep stable; next request
//     carries all 20+ accumulated steps, none lost.
//   - resp_valid with resp_result=4 -> simv_result=4 for one cycle, then 0; requests continue.
//   - resp_result=3 -> simv_result=3 held for 100 cycles; req_valid never asserts again.
//   - ACC_WIDTH=8, STEPWIDTH=4, step=15, req_ready=0 -> acc saturates at 255, simv_result=3.

Source files
------------

// File: rtl/deferred_step_control_if.sv
// ---------------------------------------------------------------------------
// deferred_step_control_if
//   Groups the step input, the bulk request handshake to the software checker,
//   the checker verdict and the result code returned to the simulation endpoint.
//
//   Signals
//     step         instructions committed this cycle (0 = none)
//     req_valid    bulk step request pending
//     req_ready    checker accepts the request this cycle
//     req_nstep    steps carried by the request, stable while req_valid
//     resp_valid   checker verdict present this cycle
//     resp_result  verdict: 0 none, 1 GOODTRAP, 2 EXCEED, 3 FAIL, 4 WARMUP
//     simv_result  result code to the endpoint (same encoding)
//
//   Modports
//     master  the step controller (drives the request and result code)
//     slave   the checker / environment side
// ---------------------------------------------------------------------------
interface deferred_step_control_if #(
    parameter int STEPWIDTH = 8,
    parameter int ACC_WIDTH = 32
);

    logic [STEPWIDTH-1:0] step;
    logic                 req_valid;
    logic                 req_ready;
    logic [ACC_WIDTH-1:0] req_nstep;
    logic                 resp_valid;
    logic [7:0]           resp_result;
    logic [7:0]           simv_result;

    modport master (
        input  step,
        input  req_ready,
        input  resp_valid,
        input  resp_result,
        output req_valid,
        output req_nstep,
        output simv_result
    );

    modport slave (
        output step,
        output req_ready,
        output resp_valid,
        output resp_result,
        input  req_valid,
        input  req_nstep,
        input  simv_result
    );

endinterface

// File: rtl/deferred_step_control.sv
// ---------------------------------------------------------------------------
// deferred_step_control
//   Batches per-cycle difftest step counts into occasional bulk requests to the
//   software checker and returns the checker's verdict to the simulation
//   endpoint as an 8-bit result code.
//
//   Parameters
//     STEPWIDTH       width of the per-cycle step count (must be < ACC_WIDTH)
//     ACC_WIDTH       width of the step accumulator and the request count
//     DEFER_INTERVAL  cycles between periodic flushes (>= 2)
//
//   Ports
//     clock   sole clock, rising edge
//     reset   asynchronous, active-low
//     bus     deferred_step_control_if.master:
//               step (in), req_valid/req_nstep (out), req_ready (in),
//               resp_valid/resp_result (in), simv_result (out)
//
//   States
//     IDLE  accumulating, waiting for the interval or a nearly full accumulator
//     REQ   request presented to the checker
//     WAIT  request accepted, waiting for the verdict
//     DONE  terminal verdict or accumulator overflow; nothing more is sent
// ---------------------------------------------------------------------------
module deferred_step_control #(
    parameter int STEPWIDTH      = 8,
    parameter int ACC_WIDTH      = 32,
    parameter int DEFER_INTERVAL = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    deferred_step_control_if.master bus
);

    localparam int CNT_WIDTH = $clog2(DEFER_INTERVAL);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEFER_INTERVAL - 1);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;
    localparam logic [ACC_WIDTH-1:0] STEP_MAX =
        {{(ACC_WIDTH - STEPWIDTH){1'b0}}, {STEPWIDTH{1'b1}}};
    // Once the accumulator reaches this value one more maximal step could
    // overflow it, so it is flushed early instead of waiting for the interval.
    localparam logic [ACC_WIDTH-1:0] ACC_LIMIT = ACC_MAX - STEP_MAX;

    localparam logic [7:0] RES_NONE   = 8'd0;
    localparam logic [7:0] RES_FAIL   = 8'd3;
    localparam logic [7:0] RES_WARMUP = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]   nstep_q, nstep_d;
    logic [7:0]             simv_q, simv_d;

    logic [ACC_WIDTH:0]     stepWide;
    logic [ACC_WIDTH:0]     sumWide;
    logic [ACC_WIDTH-1:0]   sumSat;
    logic                   cntLast;
    logic                   nearFull;
    logic                   flushNow;
    logic                   accBusy;
    logic                   satHit;
    logic                   respTerminal;
    logic                   respWarmup;

    // Shared arithmetic and decode. The sum keeps one carry bit so that an
    // overflow while a request is outstanding can be detected and clamped.
    always_comb begin
        stepWide     = {{(ACC_WIDTH + 1 - STEPWIDTH){1'b0}}, bus.step};
        sumWide      = {1'b0, acc_q} + stepWide;
        sumSat       = sumWide[ACC_WIDTH] ? ACC_MAX : sumWide[ACC_WIDTH-1:0];
        cntLast      = (cnt_q == CNT_LAST);
        nearFull     = (acc_q >= ACC_LIMIT);
        flushNow     = (state_q == ST_IDLE) && (sumWide != '0) && (cntLast || nearFull);
        accBusy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
        satHit       = accBusy && (sumWide >= {1'b0, ACC_MAX});
        respTerminal = (bus.resp_result >= 8'd1) && (bus.resp_result <= 8'd3);
        respWarmup   = (bus.resp_result == RES_WARMUP);
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Saturation while a request is outstanding wins over
    // both the handshake and any verdict arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flushNow) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (satHit) begin
                    state_d = ST_DONE;
                end else if (bus.req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (satHit) begin
                    state_d = ST_DONE;
                end else if (bus.resp_valid) begin
                    state_d = respTerminal ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: accumulator, interval counter, request count and
    // result code. Steps are added in every non-terminal state, so a step that
    // coincides with a flush, handshake or verdict is never dropped. The result
    // code defaults to zero (making WARMUP a one-cycle pulse) and only holds
    // once the terminal state has been entered.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        nstep_d = nstep_q;
        simv_d  = (state_q == ST_DONE) ? simv_q : RES_NONE;
        case (state_q)
            ST_IDLE: begin
                if (flushNow) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    nstep_d = sumSat;
                end else begin
                    acc_d = sumSat;
                    cnt_d = cntLast ? '0 : cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                acc_d = satHit ? ACC_MAX : sumWide[ACC_WIDTH-1:0];
                if (satHit) begin
                    simv_d = RES_FAIL;
                end
            end
            ST_WAIT: begin
                acc_d = satHit ? ACC_MAX : sumWide[ACC_WIDTH-1:0];
                if (satHit) begin
                    simv_d = RES_FAIL;
                end else if (bus.resp_valid) begin
                    if (respTerminal) begin
                        simv_d = bus.resp_result;
                    end else if (respWarmup) begin
                        simv_d = RES_WARMUP;
                    end else begin
                        simv_d = RES_NONE;
                    end
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            nstep_q <= '0;
            simv_q  <= RES_NONE;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nstep_q <= nstep_d;
            simv_q  <= simv_d;
        end
    end

    // Outputs are taken straight from registered state.
    always_comb begin
        bus.req_valid   = (state_q == ST_REQ);
        bus.req_nstep   = nstep_q;
        bus.simv_result = simv_q;
    end

endmodule

// File: tb/tb_deferred_step_control.sv
// ---------------------------------------------------------------------------
// tb_deferred_step_control
//   Two controllers share one clock: dutA (8-bit steps, 32-bit accumulator,
//   interval 4) exercises batching, handshake stalls and verdict handling;
//   dutB (4-bit steps, 8-bit accumulator) exercises early flush and overflow.
//   Expected request counts are queued as stimulus is applied and popped when
//   a request appears.
// ---------------------------------------------------------------------------
module tb_deferred_step_control;

    logic clock = 1'b0;
    logic resetA;
    logic resetB;

    int errors = 0;
    int checks = 0;
    int unsigned expQ[$];
    int cyc;

    always #5 clock = ~clock;

    deferred_step_control_if #(.STEPWIDTH(8), .ACC_WIDTH(32)) busA ();
    deferred_step_control_if #(.STEPWIDTH(4), .ACC_WIDTH(8))  busB ();

    deferred_step_control #(
        .STEPWIDTH(8), .ACC_WIDTH(32), .DEFER_INTERVAL(4)
    ) dutA (
        .clock(clock),
        .reset(resetA),
        .bus  (busA.master)
    );

    deferred_step_control #(
        .STEPWIDTH(4), .ACC_WIDTH(8), .DEFER_INTERVAL(1024)
    ) dutB (
        .clock(clock),
        .reset(resetB),
        .bus  (busB.master)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic rdy,
                                 input logic rv, input logic [7:0] rr);
        busA.step        = s;
        busA.req_ready   = rdy;
        busA.resp_valid  = rv;
        busA.resp_result = rr;
    endtask

    // Wait (bounded) for a request on the selected DUT, then pop the queued
    // expectation and compare it with the request count.
    task automatic waitReq(input string tag, input bit useB, input int maxCycles,
                           output int cycles);
        logic        v;
        logic [31:0] n;
        int unsigned exp;
        cycles = 0;
        v = useB ? busB.req_valid : busA.req_valid;
        while (!v && cycles < maxCycles) begin
            tick();
            cycles++;
            v = useB ? busB.req_valid : busA.req_valid;
        end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
        if (!v) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: req_valid=0 after %0d cycles, required 1", tag, maxCycles);
        end else begin
            n = useB ? {24'd0, busB.req_nstep} : busA.req_nstep;
            checkOutput(tag, n, exp);
        end
    endtask

    initial begin
        resetA = 1'b0;
        resetB = 1'b0;
        applyStimulus(8'd0, 1'b0, 1'b0, 8'd0);
        busB.step        = 4'd0;
        busB.req_ready   = 1'b0;
        busB.resp_valid  = 1'b0;
        busB.resp_result = 8'd0;
        repeat (3) tick();

        checkOutput("resetValidA", busA.req_valid, 0);
        checkOutput("resetNstepA", busA.req_nstep, 0);
        checkOutput("resetSimvA", busA.simv_result, 0);
        checkOutput("resetSimvB", busB.simv_result, 0);
        resetA = 1'b1;

        // Periodic flush: one step per cycle, first request carries 4.
        applyStimulus(8'd1, 1'b1, 1'b0, 8'd0);
        expQ.push_back(4);
        waitReq("firstFlush", 1'b0, 10, cyc);
        checkOutput("firstLatency", cyc, 4);
        tick();
        checkOutput("handshakeDrop", busA.req_valid, 0);

        // WARMUP verdict pulses the result code for one cycle.
        applyStimulus(8'd1, 1'b1, 1'b1, 8'd4);
        tick();
        checkOutput("warmupPulse", busA.simv_result, 4);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'd0);
        tick();
        checkOutput("warmupClear", busA.simv_result, 0);

        // Steps during handshake and verdict cycles are carried forward.
        expQ.push_back(6);
        waitReq("secondFlush", 1'b0, 10, cyc);
        checkOutput("secondLatency", cyc, 3);

        // Stall the checker for 10 cycles; verdicts outside WAIT are ignored.
        applyStimulus(8'd2, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("holdValid", busA.req_valid, 1);
            checkOutput("holdNstep", busA.req_nstep, 6);
            checkOutput("respIgnoredInReq", busA.simv_result, 0);
        end
        applyStimulus(8'd2, 1'b1, 1'b0, 8'd0);
        tick();
        checkOutput("stallHandshake", busA.req_valid, 0);
        applyStimulus(8'd2, 1'b1, 1'b1, 8'd0);
        tick();
        checkOutput("noneVerdict", busA.simv_result, 0);
        applyStimulus(8'd0, 1'b1, 1'b0, 8'd0);
        expQ.push_back(24);
        waitReq("heldSteps", 1'b0, 10, cyc);
        tick();

        // Out-of-range verdict behaves like "none".
        applyStimulus(8'd0, 1'b1, 1'b1, 8'd7);
        tick();
        checkOutput("code7Ignored", busA.simv_result, 0);

        // Interval expiry with nothing accumulated: no request, counter wraps.
        applyStimulus(8'd0, 1'b1, 1'b1, 8'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("emptyNoReq", busA.req_valid, 0);
            checkOutput("respIgnoredInIdle", busA.simv_result, 0);
        end
        applyStimulus(8'd5, 1'b1, 1'b0, 8'd0);
        tick();
        applyStimulus(8'd0, 1'b1, 1'b0, 8'd0);
        expQ.push_back(5);
        waitReq("afterWrap", 1'b0, 3, cyc);
        checkOutput("afterWrapLatency", cyc, 1);
        tick();

        // FAIL verdict is sticky and stops all further requests.
        applyStimulus(8'd1, 1'b1, 1'b1, 8'd3);
        tick();
        checkOutput("failSet", busA.simv_result, 3);
        applyStimulus(8'd1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            checkOutput("failSticky", busA.simv_result, 3);
            checkOutput("doneNoReq", busA.req_valid, 0);
        end

        // Asynchronous reset clears the sticky code immediately.
        resetA = 1'b0;
        #1;
        checkOutput("resetDoneSimv", busA.simv_result, 0);
        tick();
        resetA = 1'b1;

        // Reset in the middle of a stalled request.
        applyStimulus(8'd1, 1'b0, 1'b0, 8'd0);
        expQ.push_back(4);
        waitReq("postResetFlush", 1'b0, 10, cyc);
        repeat (3) tick();
        resetA = 1'b0;
        #1;
        checkOutput("midReqValid", busA.req_valid, 0);
        checkOutput("midReqNstep", busA.req_nstep, 0);
        checkOutput("midReqSimv", busA.simv_result, 0);
        tick();
        resetA = 1'b1;
        applyStimulus(8'd1, 1'b1, 1'b0, 8'd0);
        expQ.push_back(4);
        waitReq("accCleared", 1'b0, 10, cyc);
        checkOutput("accClearedLatency", cyc, 4);

        // Narrow accumulator: early flush near full, then overflow while stalled.
        busB.step      = 4'd15;
        busB.req_ready = 1'b0;
        resetB         = 1'b1;
        expQ.push_back(255);
        waitReq("nearFullFlush", 1'b1, 30, cyc);
        checkOutput("nearFullLatency", cyc, 17);
        cyc = 0;
        while (busB.simv_result != 8'd3 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("satSimv", busB.simv_result, 3);
        checkOutput("satNoReq", busB.req_valid, 0);
        busB.req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("satSticky", busB.simv_result, 3);
            checkOutput("satDoneNoReq", busB.req_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
